// File: rtl/fp16_accel_host_driver_if.sv
// Request/response and accelerator byte-bus signals of the FP16 accelerator host driver.
// The slave modport is the driver itself; master is the host/accelerator side.
interface fp16_accel_host_driver_if;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [7:0]  acc_ui;
   logic [7:0]  acc_uio;
   logic [7:0]  acc_uo;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, acc_uo,
      output req_ready, rsp_valid, rsp_data, acc_ui, acc_uio
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, acc_uo,
      input  req_ready, rsp_valid, rsp_data, acc_ui, acc_uio
   );
endinterface

// File: rtl/fp16_accel_host_driver.sv
// Host-side initiator for the byte-serial FP16 log-multiplier accelerator: serialises one
// operand pair, waits the fixed processing latency, captures the two result bytes.
module fp16_accel_host_driver #(
   parameter logic [7:0]  START_BYTE  = 8'h01,
   parameter int unsigned PROC_CYCLES = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   fp16_accel_host_driver_if.slave  bus,
   output logic                     busy
);

   typedef enum logic [2:0] {
      StIdle, StStart, StSendLo, StSendHi, StWait, StCapLo, StCapHi, StResp
   } state_e;

   localparam logic [7:0] CntLoad = 8'(PROC_CYCLES - 1);

   state_e      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  cap_lo_q, cap_lo_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        req_ready_q, req_ready_d;
   logic        busy_q, busy_d;
   logic [7:0]  ui_q, ui_d;
   logic [7:0]  uio_q, uio_d;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      cnt_d      = cnt_q;
      cap_lo_d   = cap_lo_q;
      rsp_data_d = rsp_data_q;

      case (state_q)
         StIdle: begin
            if (bus.req_valid && req_ready_q) begin
               a_d     = bus.req_a;
               b_d     = bus.req_b;
               state_d = StStart;
            end
         end
         StStart:  state_d = StSendLo;
         StSendLo: state_d = StSendHi;
         StSendHi: begin
            cnt_d   = CntLoad;
            state_d = StWait;
         end
         // Leaves WAIT so that CAP_LO lands PROC_CYCLES cycles after SEND_HI.
         StWait: begin
            if (cnt_q == 8'd1) begin
               state_d = StCapLo;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StCapLo: begin
            cap_lo_d = bus.acc_uo;
            state_d  = StCapHi;
         end
         StCapHi: begin
            rsp_data_d = {bus.acc_uo, cap_lo_q};
            state_d    = StResp;
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   // Outputs are decoded from the next state so they are registered alongside it.
   always_comb begin
      ui_d        = 8'h00;
      uio_d       = 8'h00;
      req_ready_d = (state_d == StIdle);
      rsp_valid_d = (state_d == StResp);
      busy_d      = (state_d != StIdle);
      case (state_d)
         StStart:  ui_d = START_BYTE;
         StSendLo: begin
            ui_d  = a_d[7:0];
            uio_d = b_d[7:0];
         end
         StSendHi: begin
            ui_d  = a_d[15:8];
            uio_d = b_d[15:8];
         end
         default: begin
            ui_d  = 8'h00;
            uio_d = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         cnt_q       <= 8'h00;
         cap_lo_q    <= 8'h00;
         rsp_data_q  <= 16'h0000;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         ui_q        <= 8'h00;
         uio_q       <= 8'h00;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         cap_lo_q    <= cap_lo_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         ui_q        <= ui_d;
         uio_q       <= uio_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.acc_ui    = ui_q;
   assign bus.acc_uio   = uio_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_fp16_accel_host_driver.sv
// Bench for fp16_accel_host_driver: behavioural accelerator responder plus a result
// scoreboard filled at request acceptance and drained at response handshake.
module tb_fp16_accel_host_driver;
   localparam int P = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_bad = 0;

   fp16_accel_host_driver_if bus();

   fp16_accel_host_driver #(
      .START_BYTE  (8'h01),
      .PROC_CYCLES (P)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Mitchell-style log multiply: add exponents, add mantissa fractions, carry bumps exponent.
   function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
      logic        s;
      logic [10:0] ms;
      int          e;
      s = a[15] ^ b[15];
      if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
      ms = {1'b0, a[9:0]} + {1'b0, b[9:0]};
      e  = int'(a[14:10]) + int'(b[14:10]) - 15 + int'(ms[10]);
      if (e <= 0) return {s, 15'd0};
      if (e >= 31) return {s, 5'h1f, 10'd0};
      return {s, e[4:0], ms[9:0]};
   endfunction

   // Accelerator model
   logic [1:0]  m_ph;
   int          m_t;
   logic [7:0]  m_lo_a, m_lo_b;
   logic [15:0] m_res;
   logic [7:0]  stray = 8'h00;
   logic        ovr_en = 1'b0;
   logic [15:0] ovr_val = 16'h0000;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ph <= 2'd0;
         m_t  <= 0;
      end else begin
         case (m_ph)
            2'd0: if (bus.acc_ui != 8'h00) m_ph <= 2'd1;
            2'd1: begin
               m_lo_a <= bus.acc_ui;
               m_lo_b <= bus.acc_uio;
               m_ph   <= 2'd2;
            end
            2'd2: begin
               m_res <= ovr_en ? ovr_val
                               : fp_mul({bus.acc_ui, m_lo_a}, {bus.acc_uio, m_lo_b});
               m_ph  <= 2'd3;
               m_t   <= 1;
            end
            default: begin
               if (m_t == P + 1) m_ph <= 2'd0;
               m_t <= m_t + 1;
            end
         endcase
      end
   end

   assign bus.acc_uo = (m_ph == 2'd3 && m_t == P)     ? m_res[7:0]  :
                       (m_ph == 2'd3 && m_t == P + 1) ? m_res[15:8] : stray;

   // Scoreboard monitor
   logic [15:0] sb[$];
   int          acc_cyc = 0;
   logic        rv_prev = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.req_valid && bus.req_ready) begin
            sb.push_back(ovr_en ? ovr_val : fp_mul(bus.req_a, bus.req_b));
            acc_cyc = cyc;
         end
         if (bus.rsp_valid && !rv_prev) check_val("latency", 32'(cyc - acc_cyc), 32'(P + 5));
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) check_val("sb_empty", 32'(bus.rsp_data), 32'hdead_beef);
            else check_val("rsp_data", 32'(bus.rsp_data), 32'(sb.pop_front()));
         end
         rv_prev = bus.rsp_valid;
      end else begin
         rv_prev = 1'b0;
      end
   end

   task automatic start_txn(input logic [15:0] a, input logic [15:0] b);
      bit got;
      logic [7:0] eu, ev;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_a = a;
      bus.req_b = b;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready) got = 1'b1;
      end
      if (!got) check_val("accept_tmo", 0, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_a = 16'hffff;
      bus.req_b = 16'hffff;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         case (k)
            1:       begin eu = 8'h01;   ev = 8'h00;   end
            2:       begin eu = a[7:0];  ev = b[7:0];  end
            3:       begin eu = a[15:8]; ev = b[15:8]; end
            default: begin eu = 8'h00;   ev = 8'h00;   end
         endcase
         check_val($sformatf("ui_c%0d", k), 32'(bus.acc_ui), 32'(eu));
         check_val($sformatf("uio_c%0d", k), 32'(bus.acc_uio), 32'(ev));
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      check_val("idle_tmo", 0, 1);
   endtask

   initial begin
      bit got;
      int a0;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_a = 16'h0000;
      bus.req_b = 16'h0000;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_req_ready", 32'(bus.req_ready), 1);
      check_val("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_bus", 32'({bus.acc_ui, bus.acc_uio}), 0);
      check_val("rst_rsp_data", 32'(bus.rsp_data), 0);

      // Single transaction
      start_txn(16'h3C00, 16'h4000);
      wait_idle();

      // Backpressure
      bus.rsp_ready = 1'b0;
      start_txn(16'h3C00, 16'h4000);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) got = 1'b1;
      end
      if (!got) check_val("bp_rsp_tmo", 0, 1);
      for (int i = 0; i < 5; i++) begin
         check_val("bp_valid", 32'(bus.rsp_valid), 1);
         check_val("bp_data", 32'(bus.rsp_data), 32'h4000);
         check_val("bp_req_ready", 32'(bus.req_ready), 0);
         check_val("bp_bus", 32'({bus.acc_ui, bus.acc_uio}), 0);
         @(posedge clk); #1;
         if (i == 4) bus.rsp_ready = 1'b1;
         @(negedge clk);
      end
      check_val("bp_hs_valid", 32'(bus.rsp_valid), 1);
      @(negedge clk);
      check_val("bp_after_ready", 32'(bus.req_ready), 1);
      check_val("bp_after_valid", 32'(bus.rsp_valid), 0);

      // Back-to-back with req_valid held high
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_a = 16'h3C00;
      bus.req_b = 16'h4000;
      a0 = -1;
      for (int i = 0; i < 40 && a0 < 0; i++) begin
         @(negedge clk);
         if (bus.req_ready) a0 = cyc;
      end
      @(posedge clk); #1;
      bus.req_a = 16'h4000;
      bus.req_b = 16'h4000;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            got = 1'b1;
            check_val("b2b_spacing", 32'(cyc - a0), 32'(P + 6));
         end
      end
      if (!got) check_val("b2b_tmo", 0, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      wait_idle();

      // Reset mid-WAIT
      start_txn(16'h3C00, 16'h4000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      check_val("mr_busy", 32'(busy), 0);
      check_val("mr_req_ready", 32'(bus.req_ready), 1);
      check_val("mr_rsp_valid", 32'(bus.rsp_valid), 0);
      check_val("mr_bus", 32'({bus.acc_ui, bus.acc_uio}), 0);
      check_val("mr_rsp_data", 32'(bus.rsp_data), 0);
      start_txn(16'h3C00, 16'h3C00);
      wait_idle();

      // Zero operands
      start_txn(16'h0000, 16'h0000);
      wait_idle();

      // Stray acc_uo outside the capture cycles
      stray = 8'hFF;
      ovr_en = 1'b1;
      ovr_val = 16'h1234;
      start_txn(16'h3C00, 16'h4000);
      wait_idle();
      check_val("stray_data", 32'(bus.rsp_data), 32'h1234);
      stray = 8'h00;
      ovr_en = 1'b0;

      // Random operand pairs
      for (int i = 0; i < 4; i++) begin
         start_txn(16'($urandom), 16'($urandom));
         wait_idle();
      end

      repeat (3) @(negedge clk);
      check_val("sb_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/fp16_accel_host_driver.md
Name: fp16_accel_host_driver

Overview:
- Host-side initiator for the byte-serial FP16 log-multiplier accelerator.
- Accepts a pair of 16-bit FP16 operands on a valid/ready request port and serializes them onto the accelerator's 8-bit input buses.
- Waits the accelerator's fixed processing latency, captures the two result bytes from its output bus, and presents the 16-bit product on a valid/ready response port.
- Sits between on-chip or test logic and the accelerator; one transaction outstanding at a time.

Parameters:
- START_BYTE, 8'h01, byte driven on acc_ui to start a transaction; must be nonzero.
- PROC_CYCLES, 8, cycles from the high-operand-byte cycle to the cycle in which the low result byte is valid on acc_uo; must be ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset; shared with the accelerator.
- req_valid  in  1  operand pair valid.
- req_ready  out  1  driver can accept a request.
- req_a  in  16  operand A (FP16: sign, 5-bit exponent, 10-bit mantissa).
- req_b  in  16  operand B (FP16).
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  16  FP16 product from the accelerator.
- acc_ui  out  8  to accelerator ui_in: start byte, then A bytes.
- acc_uio  out  8  to accelerator uio_in: B bytes.
- acc_uo  in  8  from accelerator uo_out: result bytes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE; acc_ui=0, acc_uio=0, rsp_valid=0, rsp_data=0, busy=0, operand and capture registers cleared.
  - Reset takes effect in any state, including mid-transaction; no partial response is produced.
- All outputs are registered; acc_ui/acc_uio are 0 in every state except START, SEND_LO and SEND_HI.
- States: IDLE, START, SEND_LO, SEND_HI, WAIT, CAP_LO, CAP_HI, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_a/req_b, go to START. req_ready=0 in all other states.
- Cycle numbering: c0 = accept cycle.
  - c1 START: acc_ui=START_BYTE, acc_uio=0.
  - c2 SEND_LO: acc_ui=A[7:0], acc_uio=B[7:0].
  - c3 SEND_HI: acc_ui=A[15:8], acc_uio=B[15:8].
  - WAIT: bus 0. A down-counter loaded with PROC_CYCLES-1 runs until the low result byte cycle, c3+PROC_CYCLES (c11 by default).
  - CAP_LO at c11: sample acc_uo into rsp_data[7:0] at the end of the cycle.
  - CAP_HI at c12: sample acc_uo into rsp_data[15:8].
  - RESP from c13: rsp_valid=1.
- Latency: accept to rsp_valid = PROC_CYCLES+5 cycles (13 by default).
- RESP: rsp_valid and rsp_data are held stable until rsp_valid&&rsp_ready, then go to IDLE with rsp_valid=0. rsp_data holds its last value.
- Minimum accept-to-accept spacing with rsp_ready held high: PROC_CYCLES+6 cycles (14). This guarantees the accelerator is back in its idle state before the next START.
- While busy, req_a/req_b/req_valid changes are ignored. The latched operands are used.
- Operand bytes equal to 0x00 are legal. Only the START cycle must be nonzero.
- acc_uo is ignored outside CAP_LO/CAP_HI.
- No timeout and no error reporting. Result correctness depends on the accelerator honouring the fixed latency.

Test Plan:
- Single transaction, A=0x3C00, B=0x4000, rsp_ready=1, real accelerator connected:
  - Bus (acc_ui/acc_uio) must read c1=0x01/0x00, c2=0x00/0x00, c3=0x3C/0x40, then 0/0.
  - rsp_valid must rise at c13 with rsp_data=0x4000.
- Backpressure: same operands, rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_valid stays 1 and rsp_data stays 0x4000.
  - req_ready=0 and the bus stays 0 throughout.
  - The handshake completes on the cycle rsp_ready rises; req_ready=1 on the next cycle.
- Back-to-back: req_valid held high with two operand pairs, (0x3C00,0x4000) then (0x4000,0x4000).
  - Accepts must be exactly 14 cycles apart.
  - The responses must be 0x4000 then 0x4400, in order.
- Reset mid-WAIT: assert rst_n=0 at c6 for one cycle.
  - Next cycle: state IDLE, rsp_valid=0, bus 0/0, rsp_data=0.
  - A following request (0x3C00,0x3C00) must return 0x3C00 at the normal 13-cycle latency.
- Zero operands: A=0x0000, B=0x0000.
  - c1 must still drive 0x01.
  - The response is whatever the accelerator returns at c11/c12, captured byte-exact against a scoreboard model of the accelerator.
- Stray acc_uo: drive 0xFF on acc_uo in every cycle except c11/c12, where the responder model drives 0x34/0x12.
  - rsp_data must be 0x1234.
